// File: rtl/clock_div_pkg.sv
// Shared types and defaults for the programmable clock divider scheduler.
package clock_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_e;

    localparam int CNT_W_DEF    = 16;
    localparam int DEF_HALF_DEF = 10;

endpackage

// File: rtl/clock_div_core.sv
// Half-period counter, registered divided clock and single-cycle edge ticks.
module clock_div_core #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] half,
    output logic             clocko,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             fall_next
);

    logic [CNT_W-1:0] cnt;
    logic             at_edge;

    assign at_edge   = (cnt == half);
    // Tells the scheduler that the coming edge is a falling one (period boundary).
    assign fall_next = enable && !restart && at_edge && clocko;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt       <= '0;
            clocko    <= 1'b0;
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
        end else begin
            tick_rise <= 1'b0;
            tick_fall <= 1'b0;
            if (restart) begin
                cnt    <= CNT_W'(1);
                clocko <= 1'b0;
            end else if (enable) begin
                if (at_edge) begin
                    cnt       <= CNT_W'(1);
                    clocko    <= ~clocko;
                    tick_rise <= ~clocko;
                    tick_fall <= clocko;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt    <= '0;
                clocko <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_div_scheduler.sv
// Run-time controller for the clock divider: start/stop/drain FSM and glitch-free ratio updates.
// Optional feature: define CLKDIV_PERIOD_CNT_EN to add the period_cnt output.
module clock_div_scheduler
    import clock_div_pkg::*;
#(
    parameter int CNT_W    = CNT_W_DEF,
    parameter int DEF_HALF = DEF_HALF_DEF
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic             stop,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_half,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clocko,
    output logic             tick_rise,
    output logic             tick_fall,
    output logic             running,
`ifdef CLKDIV_PERIOD_CNT_EN
    output logic [31:0]      period_cnt,
`endif
    output logic [CNT_W-1:0] cur_half
);

    state_e           state;
    logic             pend_vld;
    logic [CNT_W-1:0] pend_half;
    logic             cfg_xfer;
    logic             cfg_ok;
    logic             restart;
    logic             enable;
    logic             fall_next;

    assign cfg_ready = !pend_vld;
    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign cfg_ok    = cfg_xfer && (cfg_half != '0);
    assign restart   = (state == ST_IDLE) && start;
    assign enable    = (state != ST_IDLE);
    assign running   = enable;

    clock_div_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clock     (clock),
        .reset_n   (reset_n),
        .enable    (enable),
        .restart   (restart),
        .half      (cur_half),
        .clocko    (clocko),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .fall_next (fall_next)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cur_half  <= CNT_W'(DEF_HALF);
            pend_vld  <= 1'b0;
            pend_half <= '0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_err <= cfg_xfer && (cfg_half == '0);
            case (state)
                ST_IDLE: begin
                    if (cfg_ok) cur_half <= cfg_half;
                    if (start)  state    <= ST_RUN;
                end
                ST_RUN, ST_DRAIN: begin
                    if (fall_next && pend_vld) begin
                        cur_half <= pend_half;
                        pend_vld <= 1'b0;
                    end else if (cfg_ok) begin
                        // A value accepted on the final drain edge goes straight in,
                        // since no further boundary will come to apply it.
                        if (state == ST_DRAIN && fall_next) begin
                            cur_half <= cfg_half;
                        end else begin
                            pend_half <= cfg_half;
                            pend_vld  <= 1'b1;
                        end
                    end
                    if (state == ST_RUN && stop)
                        state <= ST_DRAIN;
                    else if (state == ST_DRAIN && fall_next)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef CLKDIV_PERIOD_CNT_EN
    always_ff @(posedge clock) begin
        if (!reset_n || restart)
            period_cnt <= '0;
        else if (fall_next && period_cnt != '1)
            period_cnt <= period_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_clock_div_scheduler.sv
// Self-checking bench for clock_div_scheduler against a phase-arithmetic reference model.
// Covers CLKDIV_PERIOD_CNT_EN when the macro is defined.
module tb_clock_div_scheduler;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;

    logic        clock = 1'b0;
    logic        reset_n, start, stop, cfg_valid;
    logic [15:0] cfg_half;
    logic        cfg_ready, cfg_err, clocko, tick_rise, tick_fall, running;
    logic [15:0] cur_half;
`ifdef CLKDIV_PERIOD_CNT_EN
    logic [31:0] period_cnt;
`endif

    int unsigned ntot  = 0;
    int unsigned npass = 0;
    int unsigned nfail = 0;

    // Reference model state: phase derived from cycles elapsed since the segment start.
    int unsigned cyc = 0;
    int          m_state;
    logic        m_clk;
    int unsigned m_seg;
    int unsigned m_h;
    int unsigned m_pend[$];
    int unsigned m_pc;
    logic        e_rise, e_fall, e_err;

    always #5 clock = ~clock;

    clock_div_scheduler #(
        .CNT_W    (16),
        .DEF_HALF (10)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .cfg_valid (cfg_valid),
        .cfg_half  (cfg_half),
        .cfg_ready (cfg_ready),
        .cfg_err   (cfg_err),
        .clocko    (clocko),
        .tick_rise (tick_rise),
        .tick_fall (tick_fall),
        .running   (running),
`ifdef CLKDIV_PERIOD_CNT_EN
        .period_cnt(period_cnt),
`endif
        .cur_half  (cur_half)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) begin
            npass++;
        end else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model(input logic rn, input logic st, input logic sp,
                         input logic cv, input int unsigned ch);
        int   old;
        logic prev, newclk, xfer, ok, fall;
        cyc++;
        if (!rn) begin
            m_state = M_IDLE;
            m_clk   = 1'b0;
            m_h     = 10;
            m_pend.delete();
            m_pc    = 0;
            e_rise  = 1'b0;
            e_fall  = 1'b0;
            e_err   = 1'b0;
            return;
        end
        old    = m_state;
        prev   = m_clk;
        xfer   = cv && (m_pend.size() == 0);
        ok     = xfer && (ch != 0);
        e_err  = xfer && (ch == 0);
        newclk = 1'b0;
        if (old == M_IDLE) begin
            if (ok) m_h = ch;
            if (st) begin
                m_state = M_RUN;
                m_seg   = cyc;
                m_pc    = 0;
            end
        end else begin
            newclk = (((cyc - m_seg) / m_h) % 2) == 1;
            fall   = prev && !newclk;
            if (fall && m_pend.size() > 0) begin
                m_h   = m_pend.pop_front();
                m_seg = cyc;
            end
            if (fall && old == M_DRAIN) begin
                m_state = M_IDLE;
                if (ok) m_h = ch;
            end else if (ok) begin
                m_pend.push_back(ch);
            end
            if (old == M_RUN && sp) m_state = M_DRAIN;
        end
        e_rise = !prev && newclk;
        e_fall = prev && !newclk;
        if (e_fall && m_pc != 32'hFFFF_FFFF) m_pc++;
        m_clk = newclk;
    endtask

    task automatic step(input logic rn, input logic st, input logic sp,
                        input logic cv, input int unsigned ch);
        reset_n   = rn;
        start     = st;
        stop      = sp;
        cfg_valid = cv;
        cfg_half  = 16'(ch);
        @(posedge clock);
        model(rn, st, sp, cv, ch);
        #1;
        chk("clocko",    32'(clocko),    32'(m_clk));
        chk("tick_rise", 32'(tick_rise), 32'(e_rise));
        chk("tick_fall", 32'(tick_fall), 32'(e_fall));
        chk("running",   32'(running),   32'(m_state != M_IDLE));
        chk("cur_half",  32'(cur_half),  m_h);
        chk("cfg_ready", 32'(cfg_ready), 32'(m_pend.size() == 0));
        chk("cfg_err",   32'(cfg_err),   32'(e_err));
`ifdef CLKDIV_PERIOD_CNT_EN
        chk("period_cnt", period_cnt, m_pc);
`endif
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
    endtask

    task automatic wait_high(input int unsigned extra);
        for (int i = 0; i < 300 && m_clk !== 1'b1; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        idle(extra);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_half = '0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b0, 1'b1, 1'b1, 1'b1, 5);
        chk("rst_cur_half", 32'(cur_half), 32'd10);
        chk("rst_ready",    32'(cfg_ready), 32'd1);

        // Start with default half: first rise 10 cycles after start
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(9);
        chk("first_rise_pre", 32'(clocko), 32'd0);
        idle(1);
        chk("first_rise", 32'(tick_rise), 32'd1);
        idle(45);

        // New ratio offered mid-high waits for the falling boundary
        wait_high(3);
        step(1'b1, 1'b0, 1'b0, 1'b1, 4);
        chk("cfg_pending_ready", 32'(cfg_ready), 32'd0);
        idle(40);

        // Zero ratio rejected
        step(1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk("cfg_zero_err", 32'(cfg_err), 32'd1);
        idle(5);

        // Restore half 10, then stop while high and drain
        step(1'b1, 1'b0, 1'b0, 1'b1, 10);
        idle(50);
        wait_high(2);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        idle(30);
        chk("drain_done", 32'(running), 32'd0);

        // Stop in IDLE ignored; start+stop together in IDLE starts
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 7);
        wait_high(2);

        // Reset mid-high with pending config aborts at once
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("abort_clocko", 32'(clocko), 32'd0);
        chk("abort_half",   32'(cur_half), 32'd10);
        idle(3);

        // Randomized traffic, small ratios to exercise many boundaries
        for (int i = 0; i < 2500; i++) begin
            logic rn, st, sp, cv;
            rn = ($urandom_range(0, 499) != 0);
            st = ($urandom_range(0, 29) == 0);
            sp = ($urandom_range(0, 59) == 0);
            cv = ($urandom_range(0, 7) == 0);
            step(rn, st, sp, cv, $urandom_range(0, 6));
        end

`ifdef CLKDIV_PERIOD_CNT_EN
        // Period counting at clock/2, cleared on a fresh start
        step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        idle(50);
        chk("period_cnt_50", period_cnt, 32'd25);
        step(1'b1, 1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 20 && m_state != M_IDLE; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 0);
        chk("period_cnt_clear", period_cnt, 32'd0);
`endif

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
